// File: rtl/sdl_frame_monitor.sv
// Raster-order checker and per-frame checksum / key-colour bounding box for the SDL pixel stream.
// Results and sync_err appear 1 cycle after the deciding pixel; pure sink, no backpressure (de qualifies input).
module sdl_frame_monitor #(
  parameter int         H_RES = 640,
  parameter int         V_RES = 480,
  parameter logic [7:0] KEY_R = 8'hFF,
  parameter logic [7:0] KEY_G = 8'hCC,
  parameter logic [7:0] KEY_B = 8'h00
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic [9:0]  sx,
  input  logic [9:0]  sy,
  input  logic        de,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        frame_valid,
  output logic        obj_found,
  output logic [9:0]  obj_x0,
  output logic [9:0]  obj_x1,
  output logic [9:0]  obj_y0,
  output logic [9:0]  obj_y1,
  output logic [18:0] obj_count,
  output logic [15:0] checksum,
  output logic [15:0] frame_count,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nx;
  logic [9:0]  ex, ey, ex_nx, ey_nx;

  logic        is_key, at_origin, at_exp;
  logic        start, accum, mismatch, complete;

  logic [15:0] acc_csum;
  logic [18:0] acc_cnt;
  logic        acc_found;
  logic [9:0]  acc_x0, acc_x1, acc_y0, acc_y1;

  logic [15:0] base_csum, pix_csum;
  logic [18:0] base_cnt, pix_cnt;
  logic        base_found, pix_found;
  logic [9:0]  base_x0, base_x1, base_y0, base_y1;
  logic [9:0]  pix_x0, pix_x1, pix_y0, pix_y1;

  assign is_key    = (r == KEY_R) && (g == KEY_G) && (b == KEY_B);
  assign at_origin = (sx == 10'd0) && (sy == 10'd0);
  assign at_exp    = (sx == ex) && (sy == ey);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state <= SEEK;
      ex    <= 10'd0;
      ey    <= 10'd0;
    end else begin
      state <= state_nx;
      ex    <= ex_nx;
      ey    <= ey_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ex_nx    = ex;
    ey_nx    = ey;
    start    = 1'b0;
    accum    = 1'b0;
    mismatch = 1'b0;
    complete = 1'b0;
    if (de) begin
      case (state)
        SEEK: begin
          if (at_origin) begin
            start    = 1'b1;
            state_nx = RUN;
            ex_nx    = 10'd1;
            ey_nx    = 10'd0;
          end
        end
        RUN: begin
          if (at_exp) begin
            accum = 1'b1;
            if (ex == X_LAST) begin
              ex_nx = 10'd0;
              if (ey == Y_LAST) begin
                complete = 1'b1;
                state_nx = SEEK;
                ey_nx    = 10'd0;
              end else begin
                ey_nx = ey + 10'd1;
              end
            end else begin
              ex_nx = ex + 10'd1;
            end
          end else begin
            // An out-of-order origin pixel is still a valid start of a new frame.
            mismatch = 1'b1;
            if (at_origin) begin
              start = 1'b1;
              ex_nx = 10'd1;
              ey_nx = 10'd0;
            end else begin
              state_nx = SEEK;
              ex_nx    = 10'd0;
              ey_nx    = 10'd0;
            end
          end
        end
      endcase
    end
  end

  // Accumulator view including the current pixel; a frame start folds in from zero.
  always_comb begin
    base_csum  = start ? 16'd0 : acc_csum;
    base_cnt   = start ? 19'd0 : acc_cnt;
    base_found = start ? 1'b0  : acc_found;
    base_x0    = start ? 10'd0 : acc_x0;
    base_x1    = start ? 10'd0 : acc_x1;
    base_y0    = start ? 10'd0 : acc_y0;
    base_y1    = start ? 10'd0 : acc_y1;

    pix_csum  = {base_csum[14:0], base_csum[15]} ^ {r, g} ^ {8'h00, b};
    pix_cnt   = base_cnt + 19'(is_key);
    pix_found = base_found | is_key;
    pix_x0    = base_x0;
    pix_x1    = base_x1;
    pix_y0    = base_y0;
    pix_y1    = base_y1;
    if (is_key) begin
      if (!base_found) begin
        pix_x0 = sx;
        pix_x1 = sx;
        pix_y0 = sy;
        pix_y1 = sy;
      end else begin
        if (sx < base_x0) pix_x0 = sx;
        if (sx > base_x1) pix_x1 = sx;
        if (sy < base_y0) pix_y0 = sy;
        if (sy > base_y1) pix_y1 = sy;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      acc_csum    <= 16'd0;
      acc_cnt     <= 19'd0;
      acc_found   <= 1'b0;
      acc_x0      <= 10'd0;
      acc_x1      <= 10'd0;
      acc_y0      <= 10'd0;
      acc_y1      <= 10'd0;
      frame_valid <= 1'b0;
      obj_found   <= 1'b0;
      obj_x0      <= 10'd0;
      obj_x1      <= 10'd0;
      obj_y0      <= 10'd0;
      obj_y1      <= 10'd0;
      obj_count   <= 19'd0;
      checksum    <= 16'd0;
      frame_count <= 16'd0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      frame_valid <= complete;
      sync_err    <= mismatch;
      if (mismatch && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      if (complete) begin
        obj_found   <= pix_found;
        obj_x0      <= pix_found ? pix_x0  : 10'd0;
        obj_x1      <= pix_found ? pix_x1  : 10'd0;
        obj_y0      <= pix_found ? pix_y0  : 10'd0;
        obj_y1      <= pix_found ? pix_y1  : 10'd0;
        obj_count   <= pix_found ? pix_cnt : 19'd0;
        checksum    <= pix_csum;
        frame_count <= frame_count + 16'd1;
      end

      if (complete || (mismatch && !start)) begin
        acc_csum  <= 16'd0;
        acc_cnt   <= 19'd0;
        acc_found <= 1'b0;
        acc_x0    <= 10'd0;
        acc_x1    <= 10'd0;
        acc_y0    <= 10'd0;
        acc_y1    <= 10'd0;
      end else if (start || accum) begin
        acc_csum  <= pix_csum;
        acc_cnt   <= pix_cnt;
        acc_found <= pix_found;
        acc_x0    <= pix_x0;
        acc_x1    <= pix_x1;
        acc_y0    <= pix_y0;
        acc_y1    <= pix_y1;
      end
    end
  end

endmodule

// File: tb/tb_sdl_frame_monitor.sv
// Randomized bench for sdl_frame_monitor: small 8x4 instance plus a 96x256 instance with the default key.
module tb_sdl_frame_monitor;

  localparam logic [23:0] KEY = 24'hFFCC00;
  localparam int SW = 8, SH = 4, BW = 96, BH = 256;

  typedef logic [75:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] sx = '0, sy = '0;
  logic de_s = 1'b0, de_b = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;

  logic s_fv, s_found, s_se, b_fv, b_found, b_se;
  logic [9:0] s_x0, s_x1, s_y0, s_y1, b_x0, b_x1, b_y0, b_y1;
  logic [18:0] s_cnt, b_cnt;
  logic [15:0] s_cs, s_fc, b_cs, b_fc;
  logic [7:0] s_ec, b_ec;

  int errors = 0, checks = 0;
  int exp_fc = 0, exp_err = 0;
  int mon_fv_n, mon_se_n, mon_fv_first, mon_se_first;

  logic [23:0] img [0:BH-1][0:BW-1];

  always #5 clk = ~clk;

  sdl_frame_monitor #(.H_RES(SW), .V_RES(SH)) dut_s (
    .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de(de_s), .r(r), .g(g), .b(b),
    .frame_valid(s_fv), .obj_found(s_found), .obj_x0(s_x0), .obj_x1(s_x1), .obj_y0(s_y0),
    .obj_y1(s_y1), .obj_count(s_cnt), .checksum(s_cs), .frame_count(s_fc), .sync_err(s_se),
    .err_count(s_ec));

  sdl_frame_monitor #(.H_RES(BW), .V_RES(BH)) dut_b (
    .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de(de_b), .r(r), .g(g), .b(b),
    .frame_valid(b_fv), .obj_found(b_found), .obj_x0(b_x0), .obj_x1(b_x1), .obj_y0(b_y0),
    .obj_y1(b_y1), .obj_count(b_cnt), .checksum(b_cs), .frame_count(b_fc), .sync_err(b_se),
    .err_count(b_ec));

  function automatic res_t res_s();
    return {s_found, s_x0, s_x1, s_y0, s_y1, s_cnt, s_cs};
  endfunction

  // Reference: walk the image in raster order, fold checksum, track key extent.
  function automatic res_t model(input int w, input int h);
    logic [15:0] cs;
    logic [23:0] c;
    int n, x0, x1, y0, y1;
    cs = 16'h0000; n = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        c = img[y][x];
        cs = {cs[14:0], cs[15]} ^ c[23:8] ^ {8'h00, c[7:0]};
        if (c == KEY) begin
          if (n == 0) begin x0 = x; x1 = x; y0 = y; y1 = y; end
          else begin
            if (x < x0) x0 = x;
            if (x > x1) x1 = x;
            if (y < y0) y0 = y;
            if (y > y1) y1 = y;
          end
          n++;
        end
      end
    end
    return {(n > 0), 10'(x0), 10'(x1), 10'(y0), 10'(y1), 19'(n), cs};
  endfunction

  task automatic fill(input int w, input int h, input int key_pct);
    logic [23:0] c;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        c = 24'($urandom);
        if (c == KEY) c = c ^ 24'h1;
        img[y][x] = ($urandom_range(0, 99) < key_pct) ? KEY : c;
      end
  endtask

  task automatic tick(input bit big, input bit d, input int x, input int y,
                      input logic [23:0] c, output bit fv, output bit se);
    @(negedge clk);
    fv = big ? b_fv : s_fv;
    se = big ? b_se : s_se;
    sx = 10'(x); sy = 10'(y); {r, g, b} = c;
    de_s = d && !big;
    de_b = d && big;
  endtask

  task automatic obs(input bit fv, input bit se, input int n);
    if (fv) begin mon_fv_n++; if (mon_fv_first < 0) mon_fv_first = n; end
    if (se) begin mon_se_n++; if (mon_se_first < 0) mon_se_first = n; end
  endtask

  // Streams img in raster order, optionally dropping one pixel; reports pulse counts and
  // latencies (sample step minus driving step) of frame_valid and sync_err.
  task automatic send_frame(input bit big, input int gap, input int skx, input int sky,
                            output int fv_n, output int se_n, output int fv_lat, output int se_lat);
    int w, h, n, last_n, err_n, first_n;
    bit fv, se, skipped;
    w = big ? BW : SW; h = big ? BH : SH;
    n = 0; last_n = -100; err_n = -100; first_n = -100; skipped = 0;
    mon_fv_n = 0; mon_se_n = 0; mon_fv_first = -1; mon_se_first = -1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (x == skx && y == sky) skipped = 1;
        else begin
          for (int k = 0; k < gap; k++) begin
            tick(big, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 24'($urandom), fv, se);
            n++; obs(fv, se, n);
          end
          tick(big, 1, x, y, img[y][x], fv, se);
          n++; obs(fv, se, n);
          if (first_n < 0) first_n = n;
          if (skipped && err_n < 0) err_n = n;
          last_n = n;
        end
      end
    for (int k = 0; k < 4; k++) begin
      tick(big, 0, 0, 0, 24'h0, fv, se);
      n++; obs(fv, se, n);
    end
    fv_n = mon_fv_n; se_n = mon_se_n;
    fv_lat = (mon_fv_first < 0) ? -1 : mon_fv_first - last_n;
    se_lat = (mon_se_first < 0) ? -1 : mon_se_first - (skipped ? err_n : first_n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_fv, res_s(), s_fc, s_se, s_ec} !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", {s_fv, res_s(), s_fc, s_se, s_ec});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_black_frame();
    int fv_n, se_n, fv_lat, se_lat;
    for (int y = 0; y < SH; y++) for (int x = 0; x < SW; x++) img[y][x] = 24'h0;
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    exp_fc++;
    checks++;
    if (fv_n !== 1 || fv_lat !== 1) begin
      errors++; $display("FAIL black_fv: got pulses=%0d lat=%0d want 1/1", fv_n, fv_lat);
    end
    checks++;
    if (se_n !== 0) begin errors++; $display("FAIL black_no_err: got %0d want 0", se_n); end
    checks++;
    if ({s_found, s_cs} !== 17'h0) begin
      errors++; $display("FAIL black_result: got found=%0b cs=%h want 0/0000", s_found, s_cs);
    end
    checks++;
    if (s_fc !== 16'(exp_fc)) begin errors++; $display("FAIL black_fc: got %0d want %0d", s_fc, exp_fc); end
  endtask

  task automatic test_key_box();
    int fv_n, se_n, fv_lat, se_lat;
    res_t want;
    for (int y = 0; y < SH; y++) for (int x = 0; x < SW; x++) img[y][x] = 24'h0;
    img[1][2] = KEY; img[1][3] = KEY; img[2][2] = KEY; img[2][3] = KEY;
    want = model(SW, SH);
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    exp_fc++;
    checks++;
    if ({s_found, s_x0, s_x1, s_y0, s_y1, s_cnt} !== {1'b1, 10'd2, 10'd3, 10'd1, 10'd2, 19'd4}) begin
      errors++; $display("FAIL key_box: got f=%0b x=%0d..%0d y=%0d..%0d n=%0d want 1 2..3 1..2 4",
                         s_found, s_x0, s_x1, s_y0, s_y1, s_cnt);
    end
    checks++;
    if (res_s() !== want || fv_n !== 1) begin
      errors++; $display("FAIL key_model: got %h fv=%0d want %h fv=1", res_s(), fv_n, want);
    end
  endtask

  task automatic test_gaps();
    int fv_n, se_n, fv_lat, se_lat;
    res_t want, nogap;
    fill(SW, SH, 25);
    want = model(SW, SH);
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    nogap = res_s();
    send_frame(0, 3, -1, -1, fv_n, se_n, fv_lat, se_lat);
    exp_fc += 2;
    checks++;
    if (nogap !== want) begin errors++; $display("FAIL nogap_result: got %h want %h", nogap, want); end
    checks++;
    if (res_s() !== want) begin errors++; $display("FAIL gap_result: got %h want %h", res_s(), want); end
    checks++;
    if (fv_n !== 1 || fv_lat !== 1 || se_n !== 0) begin
      errors++; $display("FAIL gap_pulses: got fv=%0d lat=%0d se=%0d want 1/1/0", fv_n, fv_lat, se_n);
    end
    checks++;
    if (s_fc !== 16'(exp_fc)) begin errors++; $display("FAIL gap_fc: got %0d want %0d", s_fc, exp_fc); end
  endtask

  task automatic test_skip(input int skx, input int sky, input string name);
    int fv_n, se_n, fv_lat, se_lat;
    res_t held, want;
    held = res_s();
    fill(SW, SH, 30);
    send_frame(0, 0, skx, sky, fv_n, se_n, fv_lat, se_lat);
    exp_err++;
    checks++;
    if (se_n !== 1 || se_lat !== 1 || fv_n !== 0) begin
      errors++; $display("FAIL %s_pulses: got se=%0d lat=%0d fv=%0d want 1/1/0", name, se_n, se_lat, fv_n);
    end
    checks++;
    if (s_ec !== 8'(exp_err) || s_fc !== 16'(exp_fc)) begin
      errors++; $display("FAIL %s_counts: got err=%0d fc=%0d want %0d/%0d", name, s_ec, s_fc, exp_err, exp_fc);
    end
    checks++;
    if (res_s() !== held) begin errors++; $display("FAIL %s_hold: got %h want %h", name, res_s(), held); end
    want = model(SW, SH);
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    exp_fc++;
    checks++;
    if (fv_n !== 1 || res_s() !== want || s_fc !== 16'(exp_fc)) begin
      errors++; $display("FAIL %s_recover: got fv=%0d res=%h fc=%0d want 1 %h %0d",
                         name, fv_n, res_s(), s_fc, want, exp_fc);
    end
  endtask

  task automatic test_restart();
    int fv_n, se_n, fv_lat, se_lat;
    bit fv, se;
    res_t want;
    fill(SW, SH, 30);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < SW; x++)
        if (y == 0 || x < 4) tick(0, 1, x, y, 24'($urandom), fv, se);
    want = model(SW, SH);
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    exp_err++; exp_fc++;
    checks++;
    if (se_n !== 1 || se_lat !== 1) begin
      errors++; $display("FAIL restart_err: got se=%0d lat=%0d want 1/1", se_n, se_lat);
    end
    checks++;
    if (fv_n !== 1 || res_s() !== want || s_ec !== 8'(exp_err)) begin
      errors++; $display("FAIL restart_frame: got fv=%0d res=%h err=%0d want 1 %h %0d",
                         fv_n, res_s(), s_ec, want, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    int fv_n, se_n, fv_lat, se_lat;
    res_t want;
    for (int f = 0; f < 4; f++) begin
      fill(SW, SH, (f == 0) ? 0 : 10 * f);
      want = model(SW, SH);
      send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
      exp_fc++;
      checks++;
      if (fv_n !== 1 || res_s() !== want || s_fc !== 16'(exp_fc)) begin
        errors++; $display("FAIL b2b_frame%0d: got fv=%0d res=%h fc=%0d want 1 %h %0d",
                           f, fv_n, res_s(), s_fc, want, exp_fc);
      end
    end
  endtask

  task automatic test_ball();
    int fv_n, se_n, fv_lat, se_lat;
    res_t want;
    fill(BW, BH, 0);
    for (int y = 230; y <= 249; y++) for (int x = 45; x <= 64; x++) img[y][x] = KEY;
    want = model(BW, BH);
    send_frame(1, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    checks++;
    if ({b_found, b_x0, b_x1, b_y0, b_y1, b_cnt} !== {1'b1, 10'd45, 10'd64, 10'd230, 10'd249, 19'd400}) begin
      errors++; $display("FAIL ball_box: got f=%0b x=%0d..%0d y=%0d..%0d n=%0d want 1 45..64 230..249 400",
                         b_found, b_x0, b_x1, b_y0, b_y1, b_cnt);
    end
    checks++;
    if (b_cs !== want[15:0]) begin errors++; $display("FAIL ball_csum: got %h want %h", b_cs, want[15:0]); end
    checks++;
    if (fv_n !== 1 || fv_lat !== 1 || b_fc !== 16'd1 || se_n !== 0) begin
      errors++; $display("FAIL ball_frame: got fv=%0d lat=%0d fc=%0d se=%0d want 1/1/1/0", fv_n, fv_lat, b_fc, se_n);
    end
  endtask

  task automatic test_saturation();
    bit fv, se;
    for (int i = 0; i < 260; i++) begin
      tick(0, 1, 0, 0, 24'h0, fv, se);
      tick(0, 1, 3, 0, 24'h0, fv, se);
    end
    tick(0, 0, 0, 0, 24'h0, fv, se);
    tick(0, 0, 0, 0, 24'h0, fv, se);
    checks++;
    if (s_ec !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d want 255", s_ec); end
  endtask

  task automatic test_reset_mid();
    int fv_n, se_n, fv_lat, se_lat;
    bit fv, se;
    res_t want;
    fill(SW, SH, 30);
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x < SW; x++)
        if (y < 2 || x <= 4) tick(0, 1, x, y, img[y][x], fv, se);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_fv, res_s(), s_fc, s_se, s_ec} !== '0) begin
      errors++; $display("FAIL async_reset_small: got %h want 0", {s_fv, res_s(), s_fc, s_se, s_ec});
    end
    checks++;
    if ({b_found, b_x0, b_x1, b_y0, b_y1, b_cnt, b_cs, b_fc, b_ec} !== '0) begin
      errors++; $display("FAIL async_reset_big: got fc=%0d cnt=%0d want 0", b_fc, b_cnt);
    end
    @(negedge clk);
    de_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(SW, SH, 30);
    want = model(SW, SH);
    send_frame(0, 0, -1, -1, fv_n, se_n, fv_lat, se_lat);
    checks++;
    if (fv_n !== 1 || s_fc !== 16'd1 || res_s() !== want || s_ec !== 8'd0) begin
      errors++; $display("FAIL post_reset_frame: got fv=%0d fc=%0d res=%h err=%0d want 1 1 %h 0",
                         fv_n, s_fc, res_s(), s_ec, want);
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit expired");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_black_frame();
    test_key_box();
    test_gaps();
    test_skip(5, 2, "skip");
    test_skip(6, 3, "final_mismatch");
    test_restart();
    test_back_to_back();
    test_ball();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
